// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the memory-command register-slice chain.
//   - Slice mode encodings selected per build through the MODE parameter.
//   - Default address/length widths and the packed command record.
//   - Helper returning the occupancy ceiling for a given mode/stage count.
package mem_cmd_pkg;

  localparam int unsigned MEM_CMD_SLICE_BYPASS = 0;
  localparam int unsigned MEM_CMD_SLICE_FULL   = 1;
  localparam int unsigned MEM_CMD_SLICE_FWD    = 2;

  localparam int unsigned MEM_CMD_ADDR_W = 64;
  localparam int unsigned MEM_CMD_LEN_W  = 32;

  typedef struct packed {
    logic [MEM_CMD_ADDR_W-1:0] address;
    logic [MEM_CMD_LEN_W-1:0]  length;
  } mem_cmd_t;

  // Commands a chain can hold: two per skid stage, one per forward stage,
  // none in bypass.
  function automatic int unsigned mem_cmd_occ_max(input int unsigned mode,
                                                  input int unsigned stages);
    int unsigned r;
    r = 0;
    if (mode == MEM_CMD_SLICE_FULL) r = 2 * stages;
    else if (mode == MEM_CMD_SLICE_FWD) r = stages;
    return r;
  endfunction

endpackage

// File: rtl/mem_cmd_slice_stage.sv
// One valid/ready register slice carrying a flat W-bit command word.
//   MODE = MEM_CMD_SLICE_FULL : skid slice, main + skid entries, registered
//                               ready, no combinational path in->out.
//   MODE = MEM_CMD_SLICE_FWD  : forward slice, single entry, ready is
//                               combinational from out_ready_i.
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   in_valid_i/in_ready_o  upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i downstream handshake, out_data_o payload
module mem_cmd_slice_stage
  import mem_cmd_pkg::*;
#(
  parameter int unsigned W    = MEM_CMD_ADDR_W + MEM_CMD_LEN_W,
  parameter int unsigned MODE = MEM_CMD_SLICE_FULL
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  generate
    if (MODE == MEM_CMD_SLICE_FWD) begin : g_fwd
      logic         valid_q, valid_d;
      logic [W-1:0] data_q, data_d;
      // Keeps ready low while in reset and releases it on the first edge after.
      logic         alive_q;

      assign in_ready_o  = alive_q && (!valid_q || out_ready_i);
      assign out_valid_o = valid_q;
      assign out_data_o  = data_q;

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
          valid_d = in_valid_i;
          if (in_valid_i) data_d = in_data_i;
        end
      end

      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          alive_q <= 1'b0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
          alive_q <= 1'b1;
        end
      end
    end else begin : g_full
      logic         main_valid_q, main_valid_d;
      logic [W-1:0] main_q, main_d;
      logic         skid_valid_q, skid_valid_d;
      logic [W-1:0] skid_q, skid_d;
      logic         rdy_q, rdy_d;
      logic         in_acc, out_acc;

      assign in_ready_o  = rdy_q;
      assign out_valid_o = main_valid_q;
      assign out_data_o  = main_q;
      assign in_acc      = in_valid_i && rdy_q;
      assign out_acc     = main_valid_q && out_ready_i;

      // rdy_q always equals !skid_valid_q out of reset, so an accepted input
      // never meets an occupied skid entry.
      always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!main_valid_q || out_acc) begin
          if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end else if (in_acc) begin
            main_valid_d = 1'b1;
            main_d       = in_data_i;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (in_acc) begin
          skid_valid_d = 1'b1;
          skid_d       = in_data_i;
        end
        rdy_d = !skid_valid_d;
      end

      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          main_valid_q <= 1'b0;
          main_q       <= '0;
          skid_valid_q <= 1'b0;
          skid_q       <= '0;
          rdy_q        <= 1'b0;
        end else begin
          main_valid_q <= main_valid_d;
          main_q       <= main_d;
          skid_valid_q <= skid_valid_d;
          skid_q       <= skid_d;
          rdy_q        <= rdy_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mem_cmd_slice_chain.sv
// Multi-stage register-slice pipeline for memory commands (address+length)
// on a valid/ready handshake, with an occupancy status counter.
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   s_cmd_valid/s_cmd_ready           upstream handshake
//   s_cmd_address/s_cmd_length        upstream command fields
//   m_cmd_valid/m_cmd_ready           downstream handshake
//   m_cmd_address/m_cmd_length        downstream command fields
//   occupancy                         commands currently held in the chain
// MODE 0 is a pure wire path; MODE 1/2 cascade STAGES slice stages.
module mem_cmd_slice_chain
  import mem_cmd_pkg::*;
#(
  parameter  int unsigned ADDR_W = MEM_CMD_ADDR_W,
  parameter  int unsigned LEN_W  = MEM_CMD_LEN_W,
  parameter  int unsigned STAGES = 1,
  parameter  int unsigned MODE   = MEM_CMD_SLICE_FULL,
  localparam int unsigned OCC_W  = $clog2(2 * STAGES + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_cmd_valid,
  output logic              s_cmd_ready,
  input  logic [ADDR_W-1:0] s_cmd_address,
  input  logic [LEN_W-1:0]  s_cmd_length,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [ADDR_W-1:0] m_cmd_address,
  output logic [LEN_W-1:0]  m_cmd_length,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int unsigned      W       = ADDR_W + LEN_W;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(mem_cmd_occ_max(MODE, STAGES));

  logic             s_acc, m_acc;
  logic [OCC_W-1:0] occ_q, occ_d;

  generate
    if (MODE == MEM_CMD_SLICE_BYPASS) begin : g_bypass
      assign m_cmd_valid   = s_cmd_valid;
      assign m_cmd_address = s_cmd_address;
      assign m_cmd_length  = s_cmd_length;
      assign s_cmd_ready   = m_cmd_ready;
      // Nothing is ever held, so the counter is pinned at zero.
      assign s_acc         = 1'b0;
      assign m_acc         = 1'b0;
    end else begin : g_chain
      logic         vld [STAGES+1];
      logic         rdy [STAGES+1];
      logic [W-1:0] dat [STAGES+1];

      assign vld[0]      = s_cmd_valid;
      assign dat[0]      = {s_cmd_address, s_cmd_length};
      assign s_cmd_ready = rdy[0];

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mem_cmd_slice_stage #(
          .W    (W),
          .MODE (MODE)
        ) u_stage (
          .aclk        (aclk),
          .areset      (areset),
          .in_valid_i  (vld[k]),
          .in_ready_o  (rdy[k]),
          .in_data_i   (dat[k]),
          .out_valid_o (vld[k+1]),
          .out_ready_i (rdy[k+1]),
          .out_data_o  (dat[k+1])
        );
      end

      assign rdy[STAGES]   = m_cmd_ready;
      assign m_cmd_valid   = vld[STAGES];
      assign m_cmd_address = dat[STAGES][W-1:LEN_W];
      assign m_cmd_length  = dat[STAGES][LEN_W-1:0];
      assign s_acc         = s_cmd_valid && s_cmd_ready;
      assign m_acc         = m_cmd_valid && m_cmd_ready;
    end
  endgenerate

  always_comb begin
    occ_d = occ_q;
    if (s_acc && !m_acc)      occ_d = occ_q + OCC_W'(1);
    else if (!s_acc && m_acc) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;

  a_occ_no_overflow: assert property (@(posedge aclk) disable iff (areset)
    !(s_acc && !m_acc && occ_q == OCC_MAX));
  a_occ_no_underflow: assert property (@(posedge aclk) disable iff (areset)
    !(m_acc && !s_acc && occ_q == '0));

endmodule

// File: tb/tb_mem_cmd_slice_chain.sv
module tb_mem_cmd_slice_chain;
  import mem_cmd_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  longint cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- MODE 1, STAGES 2 ----------------
  logic        f_rst = 1'b0, f_s_valid = 1'b0, f_s_ready, f_m_valid, f_m_ready = 1'b0;
  logic [63:0] f_s_addr = '0, f_m_addr;
  logic [31:0] f_s_len = '0, f_m_len;
  logic [2:0]  f_occ;

  mem_cmd_slice_chain #(.ADDR_W(64), .LEN_W(32), .STAGES(2), .MODE(MEM_CMD_SLICE_FULL)) u_full (
    .aclk(aclk), .areset(f_rst),
    .s_cmd_valid(f_s_valid), .s_cmd_ready(f_s_ready), .s_cmd_address(f_s_addr), .s_cmd_length(f_s_len),
    .m_cmd_valid(f_m_valid), .m_cmd_ready(f_m_ready), .m_cmd_address(f_m_addr), .m_cmd_length(f_m_len),
    .occupancy(f_occ));

  // ---------------- MODE 2, STAGES 3 ----------------
  logic        w_rst = 1'b0, w_s_valid = 1'b0, w_s_ready, w_m_valid, w_m_ready = 1'b0;
  logic [63:0] w_s_addr = '0, w_m_addr;
  logic [31:0] w_s_len = '0, w_m_len;
  logic [2:0]  w_occ;

  mem_cmd_slice_chain #(.ADDR_W(64), .LEN_W(32), .STAGES(3), .MODE(MEM_CMD_SLICE_FWD)) u_fwd (
    .aclk(aclk), .areset(w_rst),
    .s_cmd_valid(w_s_valid), .s_cmd_ready(w_s_ready), .s_cmd_address(w_s_addr), .s_cmd_length(w_s_len),
    .m_cmd_valid(w_m_valid), .m_cmd_ready(w_m_ready), .m_cmd_address(w_m_addr), .m_cmd_length(w_m_len),
    .occupancy(w_occ));

  // ---------------- MODE 0 ----------------
  logic        b_rst = 1'b0, b_s_valid = 1'b0, b_s_ready, b_m_valid, b_m_ready = 1'b0;
  logic [63:0] b_s_addr = '0, b_m_addr;
  logic [31:0] b_s_len = '0, b_m_len;
  logic [1:0]  b_occ;

  mem_cmd_slice_chain #(.ADDR_W(64), .LEN_W(32), .STAGES(1), .MODE(MEM_CMD_SLICE_BYPASS)) u_byp (
    .aclk(aclk), .areset(b_rst),
    .s_cmd_valid(b_s_valid), .s_cmd_ready(b_s_ready), .s_cmd_address(b_s_addr), .s_cmd_length(b_s_len),
    .m_cmd_valid(b_m_valid), .m_cmd_ready(b_m_ready), .m_cmd_address(b_m_addr), .m_cmd_length(b_m_len),
    .occupancy(b_occ));

  // ---------------- scoreboards / monitors ----------------
  mem_cmd_t    f_q[$];
  mem_cmd_t    f_prev;
  logic        f_stall = 1'b0;
  int unsigned f_acc = 0, f_out = 0, f_occ_max = 0;
  logic        f_track = 1'b0;
  longint      f_first_acc = -1, f_first_out = -1, f_last_out = -1;

  always @(negedge aclk) begin : mon_full
    mem_cmd_t e;
    if (f_rst) f_stall = 1'b0;
    else begin
      chk("full_occ_model", 64'(f_occ), 64'(f_q.size()));
      if (32'(f_occ) > f_occ_max) f_occ_max = 32'(f_occ);
      if (f_stall) begin
        chk("full_hold_valid", 64'(f_m_valid), 64'd1);
        chk("full_hold_addr", f_m_addr, f_prev.address);
        chk("full_hold_len", 64'(f_m_len), 64'(f_prev.length));
      end
      if (f_s_valid && f_s_ready) begin
        f_q.push_back('{address: f_s_addr, length: f_s_len});
        f_acc++;
        if (f_track && f_first_acc < 0) f_first_acc = cyc;
      end
      if (f_m_valid && f_track && f_first_out < 0) f_first_out = cyc;
      if (f_m_valid && f_m_ready) begin
        chk("full_out_pending", 64'(f_q.size() != 0), 64'd1);
        if (f_q.size() != 0) begin
          e = f_q.pop_front();
          chk("full_out_addr", f_m_addr, e.address);
          chk("full_out_len", 64'(f_m_len), 64'(e.length));
        end
        f_out++;
        if (f_track) f_last_out = cyc;
      end
      f_stall = f_m_valid && !f_m_ready;
      f_prev  = '{address: f_m_addr, length: f_m_len};
    end
  end

  mem_cmd_t    w_q[$];
  mem_cmd_t    w_prev;
  logic        w_stall = 1'b0;
  int unsigned w_acc = 0, w_out = 0, w_occ_max = 0;

  always @(negedge aclk) begin : mon_fwd
    mem_cmd_t e;
    if (w_rst) w_stall = 1'b0;
    else begin
      chk("fwd_occ_model", 64'(w_occ), 64'(w_q.size()));
      if (32'(w_occ) > w_occ_max) w_occ_max = 32'(w_occ);
      if (w_stall) begin
        chk("fwd_hold_valid", 64'(w_m_valid), 64'd1);
        chk("fwd_hold_addr", w_m_addr, w_prev.address);
        chk("fwd_hold_len", 64'(w_m_len), 64'(w_prev.length));
      end
      if (w_s_valid && w_s_ready) begin
        w_q.push_back('{address: w_s_addr, length: w_s_len});
        w_acc++;
      end
      if (w_m_valid && w_m_ready) begin
        chk("fwd_out_pending", 64'(w_q.size() != 0), 64'd1);
        if (w_q.size() != 0) begin
          e = w_q.pop_front();
          chk("fwd_out_addr", w_m_addr, e.address);
          chk("fwd_out_len", 64'(w_m_len), 64'(e.length));
        end
        w_out++;
      end
      w_stall = w_m_valid && !w_m_ready;
      w_prev  = '{address: w_m_addr, length: w_m_len};
    end
  end

  mem_cmd_t b_q[$];

  always @(negedge aclk) begin : mon_byp
    mem_cmd_t e;
    chk("byp_occ_zero", 64'(b_occ), 64'(b_q.size()));
    if (b_s_valid && b_s_ready) b_q.push_back('{address: b_s_addr, length: b_s_len});
    if (b_m_valid && b_m_ready) begin
      chk("byp_out_pending", 64'(b_q.size() != 0), 64'd1);
      if (b_q.size() != 0) begin
        e = b_q.pop_front();
        chk("byp_out_addr", b_m_addr, e.address);
        chk("byp_out_len", 64'(b_m_len), 64'(e.length));
      end
    end
  end

  // ---------------- ready pattern generators ----------------
  logic f_tog = 1'b0;
  always @(posedge aclk) if (f_tog) begin #1; f_m_ready = ~f_m_ready; end

  logic w_rnd = 1'b0;
  always @(posedge aclk) if (w_rnd) begin #1; w_m_ready = 1'($urandom_range(0, 1)); end

  // ---------------- drivers ----------------
  task automatic f_send(input logic [63:0] a, input logic [31:0] l);
    int unsigned t = 0;
    f_s_valid = 1'b1; f_s_addr = a; f_s_len = l;
    @(negedge aclk);
    while (!f_s_ready && t < 50) begin t++; @(negedge aclk); end
    if (!f_s_ready) chk("full_send_timeout", 64'(f_s_ready), 64'd1);
    @(posedge aclk); #1;
    f_s_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] a, input logic [31:0] l);
    int unsigned t = 0;
    w_s_valid = 1'b1; w_s_addr = a; w_s_len = l;
    @(negedge aclk);
    while (!w_s_ready && t < 50) begin t++; @(negedge aclk); end
    if (!w_s_ready) chk("fwd_send_timeout", 64'(w_s_ready), 64'd1);
    @(posedge aclk); #1;
    w_s_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic wait_empty(input bit fwd);
    int unsigned t = 0;
    while ((fwd ? w_q.size() : f_q.size()) != 0 && t < 300) begin @(negedge aclk); t++; end
    chk(fwd ? "fwd_drain" : "full_drain", 64'(fwd ? w_q.size() : f_q.size()), 64'd0);
    @(posedge aclk); #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned a0, o0;
    f_rst = 1'b1; w_rst = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_full_m_valid", 64'(f_m_valid), 64'd0);
    chk("rst_full_m_addr", f_m_addr, 64'd0);
    chk("rst_full_m_len", 64'(f_m_len), 64'd0);
    chk("rst_full_occ", 64'(f_occ), 64'd0);
    chk("rst_full_s_ready", 64'(f_s_ready), 64'd0);
    chk("rst_fwd_s_ready", 64'(w_s_ready), 64'd0);
    chk("rst_fwd_m_valid", 64'(w_m_valid), 64'd0);
    #2 f_rst = 1'b0; w_rst = 1'b0;
    @(posedge aclk); #1;
    chk("full_ready_after_rst", 64'(f_s_ready), 64'd1);
    chk("fwd_ready_after_rst", 64'(w_s_ready), 64'd1);

    // MODE 1 back-to-back with ready high
    f_m_ready = 1'b1; f_occ_max = 0; f_track = 1'b1; o0 = f_out;
    for (int unsigned i = 0; i < 10; i++) f_send(64'h1000 + 64'(i), 32'd64);
    idle(4);
    f_track = 1'b0;
    chk("p1_latency", 64'(f_first_out - f_first_acc), 64'd2);
    chk("p1_consecutive", 64'(f_last_out - f_first_out), 64'd9);
    chk("p1_count", 64'(f_out - o0), 64'd10);
    chk("p1_occ_peak", 64'(f_occ_max), 64'd2);
    wait_empty(1'b0);

    // MODE 1 stall: exactly four accepted, then resume without loss
    f_m_ready = 1'b0; a0 = f_acc;
    for (int unsigned i = 0; i < 4; i++) f_send(64'h3000 + 64'(i), 32'h100 + i);
    f_s_valid = 1'b1; f_s_addr = 64'h3004; f_s_len = 32'h104;
    repeat (6) @(negedge aclk);
    chk("stall_accepts", 64'(f_acc - a0), 64'd4);
    chk("stall_s_ready", 64'(f_s_ready), 64'd0);
    chk("stall_occ", 64'(f_occ), 64'd4);
    @(posedge aclk); #1;
    f_m_ready = 1'b1;
    for (int unsigned i = 4; i < 8; i++) f_send(64'h3000 + 64'(i), 32'h100 + i);
    wait_empty(1'b0);
    chk("stall_total_accepts", 64'(f_acc - a0), 64'd8);

    // Reset mid-stream with three commands held
    f_m_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) f_send(64'h4000 + 64'(i), 32'h10);
    idle(2);
    @(negedge aclk);
    chk("rst_mid_pre_occ", 64'(f_occ), 64'd3);
    @(posedge aclk); #3;
    f_rst = 1'b1; f_q.delete();
    #1;
    chk("rst_mid_m_valid", 64'(f_m_valid), 64'd0);
    chk("rst_mid_occ", 64'(f_occ), 64'd0);
    chk("rst_mid_s_ready", 64'(f_s_ready), 64'd0);
    @(posedge aclk); #3;
    f_rst = 1'b0;
    @(posedge aclk); #1;
    chk("rst_mid_ready_back", 64'(f_s_ready), 64'd1);
    chk("rst_mid_no_stale", 64'(f_m_valid), 64'd0);
    f_m_ready = 1'b1; o0 = f_out;
    f_send(64'h2000, 32'h80);
    wait_empty(1'b0);
    chk("rst_mid_out_count", 64'(f_out - o0), 64'd1);

    // Toggled ready starting from a full chain
    f_m_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) f_send(64'h5000 + 64'(i), i);
    @(negedge aclk);
    chk("tog_prefill_occ", 64'(f_occ), 64'd4);
    @(posedge aclk); #1;
    f_occ_max = 0; o0 = f_out; f_tog = 1'b1;
    for (int unsigned i = 4; i < 200; i++) f_send(64'h5000 + 64'(i), i);
    f_tog = 1'b0;
    idle(1);
    f_m_ready = 1'b1;
    wait_empty(1'b0);
    chk("tog_occ_le_4", 64'(f_occ_max <= 4), 64'd1);
    chk("tog_out_count", 64'(f_out - o0), 64'd200);

    // MODE 2, random valid gaps and random ready
    w_rnd = 1'b1; o0 = w_out; w_occ_max = 0;
    for (int unsigned i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      w_send({$urandom, $urandom}, $urandom);
    end
    w_rnd = 1'b0;
    idle(1);
    w_m_ready = 1'b1;
    wait_empty(1'b1);
    chk("fwd_occ_le_3", 64'(w_occ_max <= 3), 64'd1);
    chk("fwd_out_count", 64'(w_out - o0), 64'd1000);

    // MODE 0 combinational pass-through
    b_m_ready = 1'b1; b_s_valid = 1'b1; b_s_addr = 64'hDEADBEEF00; b_s_len = 32'h40;
    #1;
    chk("byp_m_valid", 64'(b_m_valid), 64'd1);
    chk("byp_m_addr", b_m_addr, 64'hDEADBEEF00);
    chk("byp_m_len", 64'(b_m_len), 64'h40);
    chk("byp_s_ready_hi", 64'(b_s_ready), 64'd1);
    chk("byp_occ", 64'(b_occ), 64'd0);
    b_m_ready = 1'b0;
    #1;
    chk("byp_s_ready_lo", 64'(b_s_ready), 64'd0);
    b_rst = 1'b1; b_m_ready = 1'b1;
    #1;
    chk("byp_rst_addr", b_m_addr, 64'hDEADBEEF00);
    chk("byp_rst_ready", 64'(b_s_ready), 64'd1);
    b_rst = 1'b0;
    @(posedge aclk); #1;
    b_s_valid = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
